// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - shared direction, keycode and state definitions for the sprite move scheduler
package move_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_W = 8'h1A;

    localparam int BIT_LEFT  = 0;
    localparam int BIT_RIGHT = 1;
    localparam int BIT_DOWN  = 2;
    localparam int BIT_UP    = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_DELAY  = 2'b01,
        S_REPEAT = 2'b10
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational four-way round-robin picker starting after the last grant
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant_dir,
    output logic       any
);

    logic [1:0] idx;

    // k = 4 wraps back to last itself, so a lone request on the last grant still wins
    always_comb begin
        grant_dir = last;
        any       = 1'b0;
        idx       = last;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!any && req[idx]) begin
                grant_dir = idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_move_scheduler.sv
// rtl/sprite_move_scheduler.sv - keycode decode, key-repeat FSM and step handshake for sprite movement
module sprite_move_scheduler
    import move_pkg::*;
#(
    parameter int DELAY_FRAMES = 15,
    parameter int RATE_FRAMES  = 4,
    parameter int CNT_W        = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    input  logic [3:0] edge_block,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic       repeat_active
);

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE_FRAMES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    dir_t             rr_last;
    dir_t             issue_dir;
    logic             issue;
    logic [3:0]       held, cancel, eligible, prev_eligible, new_press;
    logic [1:0]       pick_elig_dir, pick_press_dir;
    logic             elig_any, press_any;
    logic             stall;

    function automatic logic key_held(input logic [7:0] code,
                                      input logic [7:0] k0, input logic [7:0] k1,
                                      input logic [7:0] k2, input logic [7:0] k3);
        return (k0 == code) || (k1 == code) || (k2 == code) || (k3 == code);
    endfunction

    always_comb begin
        held[BIT_LEFT]  = key_held(KEY_A, keycode0, keycode1, keycode2, keycode3);
        held[BIT_RIGHT] = key_held(KEY_D, keycode0, keycode1, keycode2, keycode3);
        held[BIT_DOWN]  = key_held(KEY_S, keycode0, keycode1, keycode2, keycode3);
        held[BIT_UP]    = key_held(KEY_W, keycode0, keycode1, keycode2, keycode3);
    end

    // Opposing pairs cancel each other entirely rather than one winning
    assign cancel[BIT_RIGHT:BIT_LEFT] = {2{held[BIT_LEFT] & held[BIT_RIGHT]}};
    assign cancel[BIT_UP:BIT_DOWN]    = {2{held[BIT_DOWN] & held[BIT_UP]}};
    assign eligible  = held & ~cancel & ~edge_block;
    assign new_press = eligible & ~prev_eligible;
    assign stall     = step_valid & ~step_ready;

    rr_pick4 u_pick_elig (
        .req       (eligible),
        .last      (rr_last),
        .grant_dir (pick_elig_dir),
        .any       (elig_any)
    );

    rr_pick4 u_pick_press (
        .req       (new_press),
        .last      (rr_last),
        .grant_dir (pick_press_dir),
        .any       (press_any)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            rr_last       <= DIR_UP;
            prev_eligible <= 4'b0000;
            step_valid    <= 1'b0;
            step_dir      <= 2'b00;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            prev_eligible <= eligible;
            if (issue) begin
                step_valid <= 1'b1;
                step_dir   <= issue_dir;
                rr_last    <= issue_dir;
            end else if (step_ready) begin
                step_valid <= 1'b0;
            end
        end
    end

    // Releasing every key exits to idle even while stalled; otherwise a stall freezes everything
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        issue     = 1'b0;
        issue_dir = dir_t'(pick_elig_dir);
        case (state)
            S_IDLE: begin
                if (!stall && elig_any) begin
                    issue     = 1'b1;
                    cnt_nxt   = DELAY_LOAD;
                    state_nxt = S_DELAY;
                end
            end
            S_DELAY, S_REPEAT: begin
                if (!elig_any) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (!stall) begin
                    if (press_any) begin
                        issue     = 1'b1;
                        issue_dir = dir_t'(pick_press_dir);
                        cnt_nxt   = DELAY_LOAD;
                        state_nxt = S_DELAY;
                    end else if (cnt == '0) begin
                        issue     = 1'b1;
                        cnt_nxt   = RATE_LOAD;
                        state_nxt = S_REPEAT;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        repeat_active = (state == S_REPEAT);
    end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// tb/tb_sprite_move_scheduler.sv - directed table and sequence bench for sprite_move_scheduler
module tb_sprite_move_scheduler;

    localparam logic [7:0] KA = 8'h04;
    localparam logic [7:0] KD = 8'h07;
    localparam logic [7:0] KS = 8'h16;
    localparam logic [7:0] KW = 8'h1A;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic [3:0] edge_block;
    logic       step_ready;
    logic       step_valid;
    logic [1:0] step_dir;
    logic       repeat_active;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] k0, k1, k2, k3;
        logic [3:0] eb;
        logic       rdy;
        logic       ev;
        logic [1:0] ed;
        logic       er;
    } vec_t;

    vec_t tv[14];

    sprite_move_scheduler dut (
        .frame_clk     (frame_clk),
        .Reset         (Reset),
        .keycode0      (keycode0),
        .keycode1      (keycode1),
        .keycode2      (keycode2),
        .keycode3      (keycode3),
        .edge_block    (edge_block),
        .step_ready    (step_ready),
        .step_valid    (step_valid),
        .step_dir      (step_dir),
        .repeat_active (repeat_active)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_keys(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        keycode0 = a; keycode1 = b; keycode2 = c; keycode3 = d;
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        edge_block = 4'b0000;
        step_ready = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    function automatic logic is_step(input int n);
        return (n == 0) || (n == 15) || (n == 19) || (n == 23) || (n == 27);
    endfunction

    initial begin
        logic [1:0] ed;

        tv[0]  = '{KA, KD, KW, 8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0};
        tv[1]  = '{KA, KD, KW, 8'h00, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0};
        tv[2]  = '{KA, KD, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0};
        tv[3]  = '{KA, KD, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0};
        tv[4]  = '{KW, KD, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0};
        tv[5]  = '{KW, KD, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd1, 1'b0};
        tv[6]  = '{KW, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd1, 1'b0};
        tv[7]  = '{KW, KA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0};
        tv[8]  = '{KW, KA, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[9]  = '{KW, KA, 8'h00, 8'h00, 4'h8, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[10] = '{KW, KA, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 2'd0, 1'b0};
        tv[11] = '{KW, KA, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        tv[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0};
        tv[13] = '{KW, KW, 8'h05, 8'h00, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0};

        // reset state
        do_reset();
        chk("reset_valid", step_valid, 1'b0);
        chk("reset_dir", step_dir, 2'd0);
        chk("reset_repeat", repeat_active, 1'b0);

        // cancel, round-robin, lost press during stall, duplicates
        do_reset();
        for (int i = 0; i < 14; i++) begin
            set_keys(tv[i].k0, tv[i].k1, tv[i].k2, tv[i].k3);
            edge_block = tv[i].eb;
            step_ready = tv[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), step_valid, tv[i].ev);
            chk($sformatf("vec%0d_dir", i), step_dir, tv[i].ed);
            chk($sformatf("vec%0d_repeat", i), repeat_active, tv[i].er);
        end

        // W held 30 frames, then released
        do_reset();
        set_keys(KW, 8'h00, 8'h00, 8'h00);
        for (int n = 0; n < 30; n++) begin
            tick();
            chk($sformatf("hold_w_valid_e%0d", n), step_valid, is_step(n));
            chk($sformatf("hold_w_dir_e%0d", n), step_dir, 2'd3);
            chk($sformatf("hold_w_repeat_e%0d", n), repeat_active, n >= 15);
        end
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk($sformatf("release_valid_%0d", n), step_valid, 1'b0);
            chk($sformatf("release_repeat_%0d", n), repeat_active, 1'b0);
        end

        // W+D alternates starting with RIGHT
        do_reset();
        set_keys(KW, KD, 8'h00, 8'h00);
        ed = 2'd1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 15 || n == 23) ed = 2'd3;
            if (n == 19 || n == 27) ed = 2'd1;
            chk($sformatf("diag_valid_e%0d", n), step_valid, is_step(n));
            chk($sformatf("diag_dir_e%0d", n), step_dir, ed);
        end

        // stall for 5 edges after E0 pushes the first repeat to E20
        do_reset();
        set_keys(KW, 8'h00, 8'h00, 8'h00);
        tick();
        chk("stall_e0_valid", step_valid, 1'b1);
        step_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk($sformatf("stall_hold_valid_e%0d", n), step_valid, 1'b1);
            chk($sformatf("stall_hold_dir_e%0d", n), step_dir, 2'd3);
        end
        step_ready = 1'b1;
        for (int n = 6; n <= 20; n++) begin
            tick();
            chk($sformatf("stall_after_valid_e%0d", n), step_valid, n == 20);
        end
        chk("stall_e20_repeat", repeat_active, 1'b1);

        // edge_block masks UP until cleared at E10
        do_reset();
        set_keys(KW, 8'h00, 8'h00, 8'h00);
        edge_block = 4'b1000;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk($sformatf("blocked_valid_e%0d", n), step_valid, 1'b0);
        end
        edge_block = 4'b0000;
        tick();
        chk("unblock_e10_valid", step_valid, 1'b1);
        chk("unblock_e10_dir", step_dir, 2'd3);

        // asynchronous reset mid-stall
        do_reset();
        set_keys(KW, 8'h00, 8'h00, 8'h00);
        step_ready = 1'b0;
        tick();
        tick();
        chk("pre_reset_valid", step_valid, 1'b1);
        #2 Reset = 1'b1;
        #1;
        chk("async_reset_valid", step_valid, 1'b0);
        chk("async_reset_repeat", repeat_active, 1'b0);
        #1 Reset = 1'b0;
        step_ready = 1'b1;
        tick();
        chk("post_reset_valid", step_valid, 1'b1);
        chk("post_reset_dir", step_dir, 2'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
